// File: rtl/mem_access_ctrl.sv
// MAR/MDR memory access sequencer: Moore FSM driving register loads, MDR mux select and read/write strobes.
// Optional stalled-access watchdog compiled in with MEM_TIMEOUT_EN (TIMEOUT wait cycles before abort).
module mem_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic rw,
  input  logic mem_ready,
  output logic mar_in,
  output logic mdr_in,
  output logic md_mux_select,
  output logic mem_read,
  output logic mem_write,
  output logic busy,
  output logic done,
  output logic error
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_MAR   = 3'd1,
    LOAD_MDR   = 3'd2,
    READ_WAIT  = 3'd3,
    LATCH      = 3'd4,
    WRITE_WAIT = 3'd5,
    DONE       = 3'd6
  } state_t;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_access_ctrl: TIMEOUT must be in 1..255");
  end

  state_t state_q, state_d;
  logic   rw_q, rw_d;

`ifdef MEM_TIMEOUT_EN
  // Abort on the TIMEOUT-th stalled wait cycle, so the strobe is high exactly TIMEOUT cycles.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       limit_hit;
  assign limit_hit = (cnt_q == LIMIT) && !mem_ready;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_MAR;
          rw_d    = rw;
        end
      end
      LOAD_MAR: begin
        state_d = rw_q ? LOAD_MDR : READ_WAIT;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      LOAD_MDR: begin
        state_d = WRITE_WAIT;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      READ_WAIT, WRITE_WAIT: begin
        // mem_ready on the limit cycle takes priority over the abort.
        if (mem_ready) begin
          state_d = (state_q == READ_WAIT) ? LATCH : DONE;
`ifdef MEM_TIMEOUT_EN
        end else if (limit_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      LATCH: state_d = DONE;
      DONE: begin
        state_d = IDLE;
`ifdef MEM_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mar_in        = 1'b0;
    mdr_in        = 1'b0;
    md_mux_select = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    done          = 1'b0;
    busy          = (state_q != IDLE);
    case (state_q)
      LOAD_MAR:   mar_in = 1'b1;
      LOAD_MDR:   mdr_in = 1'b1;
      READ_WAIT: begin
        mem_read      = 1'b1;
        md_mux_select = 1'b1;
      end
      LATCH: begin
        mdr_in        = 1'b1;
        md_mux_select = 1'b1;
      end
      WRITE_WAIT: mem_write = 1'b1;
      DONE:       done      = 1'b1;
      default: ;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  assign error = (state_q == DONE) && err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: driver pushes per-access expectations computed from the
// access rules; a negedge monitor tallies each access's outputs and compares on the done pulse.
module tb_mem_access_ctrl;
  localparam int T = 15;

  logic clk, reset_n, start, rw, mem_ready;
  logic mar_in, mdr_in, md_mux_select, mem_read, mem_write, busy, done, error;

  mem_access_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .mem_ready(mem_ready),
    .mar_in(mar_in), .mdr_in(mdr_in), .md_mux_select(md_mux_select),
    .mem_read(mem_read), .mem_write(mem_write), .busy(busy), .done(done), .error(error)
  );

  typedef struct packed {
    logic [7:0] lat;
    logic [7:0] mar;
    logic [7:0] mdr_rd;
    logic [7:0] mdr_wr;
    logic [7:0] rd;
    logic [7:0] wr;
    logic [7:0] mux;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t obs;
  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] outs();
    return {mar_in, mdr_in, md_mux_select, mem_read, mem_write, busy, done, error};
  endfunction

  // Reference: one access = LOAD_MAR, optional MDR load for writes, (waits+1) strobe cycles,
  // a latch cycle for reads, then done; an abort replaces the wait tail with exactly T strobes.
  function automatic exp_t model(input bit wr_acc, input int waits);
    exp_t e;
    bit   abort;
    e = '0;
    abort = 1'b0;
`ifdef MEM_TIMEOUT_EN
    abort = (waits >= T);
`endif
    e.mar = 8'd1;
    e.err = abort;
    if (wr_acc) begin
      e.mdr_wr = 8'd1;
      e.wr     = abort ? 8'(T) : 8'(waits + 1);
      e.lat    = abort ? 8'(T + 3) : 8'(waits + 4);
    end else if (abort) begin
      e.rd  = 8'(T);
      e.mux = 8'(T);
      e.lat = 8'(T + 2);
    end else begin
      e.rd     = 8'(waits + 1);
      e.mdr_rd = 8'd1;
      e.mux    = 8'(waits + 2);
      e.lat    = 8'(waits + 4);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      obs = '0;
    end else begin
      tests++;
      if ((mem_read && mem_write) || (mar_in && mdr_in) || (error && !done)) begin
        fails++;
        $display("FAIL exclusivity t=%0t: outputs=%b, required no rd&wr, no mar&mdr, no error without done", $time, outs());
      end
      if (busy) begin
        obs.lat    = obs.lat + 8'd1;
        obs.mar    = obs.mar + 8'(mar_in);
        obs.mdr_rd = obs.mdr_rd + 8'(mdr_in && md_mux_select);
        obs.mdr_wr = obs.mdr_wr + 8'(mdr_in && !md_mux_select);
        obs.rd     = obs.rd + 8'(mem_read);
        obs.wr     = obs.wr + 8'(mem_write);
        obs.mux    = obs.mux + 8'(md_mux_select);
        if (done) begin
          obs.err = error;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_done t=%0t: got done, required no outstanding access", $time);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (obs != e) begin
              fails++;
              $display("FAIL access t=%0t: got lat=%0d mar=%0d mdr_rd=%0d mdr_wr=%0d rd=%0d wr=%0d mux=%0d err=%0d, required lat=%0d mar=%0d mdr_rd=%0d mdr_wr=%0d rd=%0d wr=%0d mux=%0d err=%0d",
                       $time, obs.lat, obs.mar, obs.mdr_rd, obs.mdr_wr, obs.rd, obs.wr, obs.mux, obs.err,
                       e.lat, e.mar, e.mdr_rd, e.mdr_wr, e.rd, e.wr, e.mux, e.err);
            end
          end
          obs = '0;
        end
      end else begin
        tests++;
        if (outs() != 8'd0 || obs != '0) begin
          fails++;
          $display("FAIL idle_outputs t=%0t: got outputs=%b partial=%0d, required all zero", $time, outs(), obs.lat);
        end
        obs = '0;
      end
    end
  end

  // Called in an IDLE cycle (#1 after the edge); returns #1 after the edge into the next IDLE cycle.
  task automatic run_txn(input bit wr_acc, input int waits, input bit force_extra);
    exp_t e;
    int   lat;
    int   ws;
    e   = model(wr_acc, waits);
    lat = int'(e.lat);
    ws  = wr_acc ? 3 : 2;
    exp_q.push_back(e);
    start     = 1'b1;
    rw        = wr_acc;
    mem_ready = 1'($urandom_range(0, 1));
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      start = (force_extra && k == 2) || ($urandom_range(0, 3) == 0);
      rw    = 1'($urandom_range(0, 1));
      if (k < ws)              mem_ready = 1'($urandom_range(0, 1));
      else if (k < ws + waits) mem_ready = 1'b0;
      else                     mem_ready = 1'b1;
    end
    @(posedge clk); #1;
    start     = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (outs() != 8'd0) begin
      fails++;
      $display("FAIL %s: got outputs=%b, required 00000000", name, outs());
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; rw = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset_hold");
    reset_n = 1'b1;
    #2 check_zero("first_cycle_after_release");

    // Reset asserted while the read strobe is up.
    @(posedge clk); #1;
    start = 1'b1; rw = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (mem_read !== 1'b1) begin
      fails++;
      $display("FAIL mid_read_strobe: got mem_read=%b, required 1", mem_read);
    end
    reset_n = 1'b0;
    #1 check_zero("async_reset_mid_read");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b0, 0, 1'b0);
    run_txn(1'b1, 3, 1'b0);
    run_txn(1'b1, 0, 1'b1);
`ifdef MEM_TIMEOUT_EN
    run_txn(1'b0, T, 1'b0);
    run_txn(1'b0, T - 1, 1'b0);
    run_txn(1'b1, T + 2, 1'b0);
    run_txn(1'b1, T - 1, 1'b0);
`endif
    for (int n = 0; n < 60; n++) begin
      bit wr_acc;
      int waits;
      int gap;
      wr_acc = 1'($urandom_range(0, 1));
`ifdef MEM_TIMEOUT_EN
      waits = $urandom_range(0, T + 2);
`else
      waits = $urandom_range(0, 20);
`endif
      gap = $urandom_range(0, 2);
      run_txn(wr_acc, waits, 1'b0);
      repeat (gap) begin
        @(posedge clk); #1;
        mem_ready = 1'($urandom_range(0, 1));
        rw        = 1'($urandom_range(0, 1));
      end
    end

    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d accesses without done, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
